// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - MEM-stage data RAM responder with programmable wait states and stall request
// Optional out-of-range checking on upper address bits: DATA_RAM_RANGE_CHECK_EN
module data_ram_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic [3:0]  ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    output logic [31:0] ram_read_data,
    output logic        ram_ready,
    output logic        stall_req,
    output logic        addr_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic                  commit;
    logic                  out_of_range;

    assign idx    = addr_q[ADDR_WIDTH+1:2];
    assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

`ifdef DATA_RAM_RANGE_CHECK_EN
    assign out_of_range = |addr_q[31:ADDR_WIDTH+2];
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr_q[1:0]};
`else
    // Upper address bits alias onto the word index when range checking is off.
    assign out_of_range = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr_q[31:ADDR_WIDTH+2], addr_q[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ram_en) begin
                    addr_d  = ram_addr;
                    strb_d  = ram_write_en;
                    wdata_d = ram_write_data;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    err_d   = out_of_range;
                    if (strb_q == 4'b0000) begin
                        rdata_d = out_of_range ? 32'd0 : mem[idx];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            strb_q  <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Reset coinciding with the commit edge must drop the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && (strb_q != 4'b0000) && !out_of_range) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign stall_req     = ((state_q == IDLE) && ram_en) || (state_q == BUSY);
    assign ram_read_data = rdata_q;
    assign ram_ready     = ready_q;
    assign addr_err      = err_q;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - scoreboard bench for data_ram_ctrl with randomized accesses
module tb_data_ram_ctrl;
    localparam int AW = 10;
    localparam int W  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        ram_ready;
    logic        stall_req;
    logic        addr_err;

    data_ram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data),
        .ram_ready      (ram_ready),
        .stall_req      (stall_req),
        .addr_err       (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          gap;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mm [1 << AW];
    logic [31:0] last_rd = 32'd0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          run = 0;
    int          last_ready_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per ram_ready pulse.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            run = 0;
        end else begin
            if (stall_req) run++;
            if (ram_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("read_data", ram_read_data, e.rd);
                    chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
                    chk("stall_cycles", 32'(run), 32'(W + 2));
                    if (e.gap != 0) chk("ready_gap", 32'(cyc - last_ready_cyc), 32'(e.gap));
                end
                run = 0;
                last_ready_cyc = cyc;
            end
        end
    end

    task automatic req(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd, input int gap);
        exp_t e;
        int   idx;
        logic oor;
        logic got;
        idx = int'(addr[AW+1:2]);
`ifdef DATA_RAM_RANGE_CHECK_EN
        oor = (addr[31:AW+2] != '0);
`else
        oor = 1'b0;
`endif
        if (we != 4'b0000) begin
            if (!oor)
                for (int i = 0; i < 4; i++)
                    if (we[i]) mm[idx][8*i +: 8] = wd[8*i +: 8];
        end else begin
            last_rd = oor ? 32'd0 : mm[idx];
        end
        e.rd = last_rd; e.err = oor; e.gap = gap;
        sb.push_back(e);
        ram_en = 1'b1; ram_write_en = we; ram_addr = addr; ram_write_data = wd;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ram_ready) begin got = 1'b1; break; end
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        ram_en = 1'b0; ram_write_en = 4'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        int          wait_k;
        rst = 1'b1; ram_en = 1'b0; ram_write_en = 4'd0; ram_addr = 32'd0; ram_write_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read_data", ram_read_data, 32'd0);
        chk("rst_ready", {31'd0, ram_ready}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        rst = 1'b0;
        idle();

        for (int i = 0; i < 16; i++) begin
            req(4'hF, 32'(i << 2), $urandom, 0);
            idle();
        end

        req(4'hF, 32'h40, 32'hDEADBEEF, 0); idle();
        req(4'h0, 32'h40, 32'd0, 0);        idle();
        req(4'hF, 32'h80, 32'h11223344, 0); idle();
        req(4'b0010, 32'h80, 32'h0000AA00, 0); idle();
        req(4'h0, 32'h80, 32'd0, 0);
        chk("byte_lane_model", mm[32], 32'h1122AA44);
        idle();

        req(4'h0, 32'h40, 32'd0, 0);
        req(4'h0, 32'h80, 32'd0, W + 3);
        idle();

        // Reset in the BUSY cycle before commit drops the write.
        ram_en = 1'b1; ram_write_en = 4'hF; ram_addr = 32'h40; ram_write_data = 32'hFFFFFFFF;
        @(posedge clk); #1;
        rst = 1'b1; ram_en = 1'b0; ram_write_en = 4'd0;
        #1;
        chk("midrst_read_data", ram_read_data, 32'd0);
        chk("midrst_ready", {31'd0, ram_ready}, 32'd0);
        chk("midrst_stall", {31'd0, stall_req}, 32'd0);
        chk("midrst_addr_err", {31'd0, addr_err}, 32'd0);
        last_rd = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        req(4'h0, 32'h40, 32'd0, 0); idle();

        req(4'hF, 32'h00001000, 32'hCAFEF00D, 0); idle();
        req(4'h0, 32'h00001000, 32'd0, 0);        idle();
        req(4'h0, 32'h00000000, 32'd0, 0);        idle();

        for (int n = 0; n < 150; n++) begin
            a = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = a | ($urandom & 32'hFFFF_F000);
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            req(we, a, $urandom, 0);
            if ($urandom_range(0, 1) == 0) begin
                idle();
            end else begin
                a = 32'($urandom_range(0, 15) << 2);
                req(4'h0, a, 32'd0, W + 3);
                idle();
            end
        end

        wait_k = 0;
        while (sb.size() != 0 && wait_k < 50) begin
            @(posedge clk); #1;
            wait_k++;
        end
        if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
